// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot burst decoder.
// Holds the two-state FSM encoding and a width-capped one-hot helper.
package decoder_pkg;

   // Widest select the helper function supports.
   localparam int MAX_SEL_W = 8;
   localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

   // IDLE waits for a request; EMIT presents one strobe per beat.
   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Returns 1 << idx at the package-wide maximum width.
   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
      logic [MAX_OUT_W-1:0] one;
      one = '0;
      one[0] = 1'b1;
      return one << idx;
   endfunction

endpackage

// File: rtl/and_gate.sv
// N-input AND primitive used by the gate-level decoder.
module and_gate #(
   parameter int N = 2
) (
   input  logic [N-1:0] a,
   output logic         y
);

   // Reduce all inputs with AND.
   always_comb y = &a;

endmodule

// File: rtl/not_gate.sv
// Single-bit inverter primitive used by the gate-level decoder.
module not_gate (
   input  logic a,
   output logic y
);

   // Invert the input.
   always_comb y = ~a;

endmodule

// File: rtl/onehot_decoder.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder built from gate primitives.
// Output o is the AND of, for every select bit b, either sel[b] or its inverse,
// chosen by bit b of o.
module onehot_decoder
   import decoder_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input  logic [SEL_W-1:0]      sel,
   output logic [2**SEL_W-1:0]   dec
);

   localparam int OUT_W = 2 ** SEL_W;

   logic [SEL_W-1:0] sel_n;

   // One inverter per select bit, shared by all output terms.
   for (genvar b = 0; b < SEL_W; b++) begin : g_inv
      not_gate u_not (
         .a (sel[b]),
         .y (sel_n[b])
      );
   end

   // One AND term per output, picking true or inverted literals.
   for (genvar o = 0; o < OUT_W; o++) begin : g_out
      logic [SEL_W-1:0] lits;
      for (genvar b = 0; b < SEL_W; b++) begin : g_lit
         if (((o >> b) % 2) != 0) begin : g_true
            assign lits[b] = sel[b];
         end else begin : g_inv_lit
            assign lits[b] = sel_n[b];
         end
      end
      and_gate #(
         .N (SEL_W)
      ) u_and (
         .a (lits),
         .y (dec[o])
      );
   end

endmodule

// File: rtl/onehot_burst_decoder.sv
// Registered one-hot strobe generator with valid/ready handshakes and burst mode.
// Direct mode emits a single strobe at sel; burst mode walks len+1 consecutive
// outputs starting at sel, wrapping modulo 2**SEL_W.
// Optional feature: define DECODER_BURST_REVERSE_EN to add the dir input, which
// makes bursts descend instead of ascend.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds in_valid and its fields until accepted; the
// consumer takes the current strobe when out_valid && out_ready. busy mirrors
// the FSM state (high in EMIT), so it doubles as the state observation point.
module onehot_burst_decoder
   import decoder_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 burst,
   input  logic [SEL_W-1:0]     len,
`ifdef DECODER_BURST_REVERSE_EN
   input  logic                 dir,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2**SEL_W-1:0]  out_onehot,
   output logic                 busy
);

   localparam int              OUT_W = 2 ** SEL_W;
   localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  idx_q, idx_d;
   logic [SEL_W-1:0]  remaining_q, remaining_d;
   logic [OUT_W-1:0]  out_onehot_q, out_onehot_d;
   logic [OUT_W-1:0]  dec_out;
   logic [SEL_W-1:0]  idx_step;
   logic              accept;
`ifdef DECODER_BURST_REVERSE_EN
   logic              dir_q, dir_d;
`endif

   // Accept in IDLE, or on the final beat so the next request follows without a bubble.
   always_comb begin
      in_ready = (state_q == IDLE) ||
                 ((state_q == EMIT) && out_ready && (remaining_q == '0));
      accept   = in_valid && in_ready;
   end

   // Index of the next burst beat; wraps naturally at SEL_W bits.
   always_comb begin
`ifdef DECODER_BURST_REVERSE_EN
      idx_step = dir_q ? (idx_q - ONE) : (idx_q + ONE);
`else
      idx_step = idx_q + ONE;
`endif
   end

   // Next-state logic: load on accept, step on a consumed non-final beat, drop to IDLE after the last.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      remaining_d = remaining_q;
`ifdef DECODER_BURST_REVERSE_EN
      dir_d       = dir_q;
`endif
      if (accept) begin
         state_d     = EMIT;
         idx_d       = sel;
         remaining_d = burst ? len : '0;
`ifdef DECODER_BURST_REVERSE_EN
         dir_d       = dir;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            EMIT: begin
               if (out_ready) begin
                  if (remaining_q != '0) begin
                     idx_d       = idx_step;
                     remaining_d = remaining_q - ONE;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   onehot_decoder #(
      .SEL_W (SEL_W)
   ) u_dec (
      .sel (idx_d),
      .dec (dec_out)
   );

   // Strobe register input: decoded next index, forced to zero when nothing will be valid.
   always_comb begin
      out_onehot_d = (state_d == EMIT) ? dec_out : '0;
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         remaining_q  <= '0;
         out_onehot_q <= '0;
`ifdef DECODER_BURST_REVERSE_EN
         dir_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         remaining_q  <= remaining_d;
         out_onehot_q <= out_onehot_d;
`ifdef DECODER_BURST_REVERSE_EN
         dir_q        <= dir_d;
`endif
      end
   end

   // Outputs come straight from registered state.
   always_comb begin
      out_valid  = (state_q == EMIT);
      busy       = (state_q == EMIT);
      out_onehot = out_onehot_q;
   end

endmodule

// File: tb/tb_onehot_burst_decoder.sv
// Bench for onehot_burst_decoder (SEL_W = 2). A queue holds the strobes still
// owed by the request in flight; every cycle the DUT outputs are compared with it.
module tb_onehot_burst_decoder;

   localparam int SEL_W = 2;
   localparam int OUT_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] sel;
   logic             burst;
   logic [SEL_W-1:0] len;
   logic             dir_i;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_onehot;
   logic             busy;

   logic [OUT_W-1:0] exp_q[$];
   int               n_checks;
   int               n_pass;

   onehot_burst_decoder #(
      .SEL_W (SEL_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sel        (sel),
      .burst      (burst),
      .len        (len),
`ifdef DECODER_BURST_REVERSE_EN
      .dir        (dir_i),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .busy       (busy)
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Reference model: an accepted request owes len+1 (or 1) strobes at sel, sel+-1, ... mod OUT_W.
   task automatic push_req(input logic [SEL_W-1:0] s, input logic b,
                           input logic [SEL_W-1:0] l, input logic d);
      int n;
      int step;
      int idx;
      logic [OUT_W-1:0] one;
      one  = 1;
      n    = b ? int'(l) + 1 : 1;
      step = 1;
`ifdef DECODER_BURST_REVERSE_EN
      if (d) step = -1;
`endif
      for (int k = 0; k < n; k++) begin
         idx = ((int'(s) + k * step) % OUT_W + OUT_W) % OUT_W;
         exp_q.push_back(one << idx);
      end
   endtask

   // Driver: one clock cycle with the given inputs, checking outputs against the model.
   task automatic cycle(input logic v, input logic [SEL_W-1:0] s, input logic b,
                        input logic [SEL_W-1:0] l, input logic d, input logic ordy);
      logic exp_rdy;
      logic take;
      logic acc;
      logic [OUT_W-1:0] exp_oh;
      @(negedge clk);
      in_valid  = v;
      sel       = s;
      burst     = b;
      len       = l;
      dir_i     = d;
      out_ready = ordy;
      #1;
      exp_oh = '0;
      if (exp_q.size() != 0) exp_oh = exp_q[0];
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("out_onehot", 32'(out_onehot), 32'(exp_oh));
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      take = (exp_q.size() != 0) && ordy;
      acc  = v && exp_rdy;
      @(posedge clk);
      if (take) void'(exp_q.pop_front());
      if (acc) push_req(s, b, l, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
   endtask

   // Asynchronous reset pulse away from the clock edges.
   task automatic reset_mid();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_onehot", 32'(out_onehot), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      sel       = '0;
      burst     = 1'b0;
      len       = '0;
      dir_i     = 1'b0;
      out_ready = 1'b1;
      #7;
      check("init_out_valid", 32'(out_valid), 32'd0);
      check("init_out_onehot", 32'(out_onehot), 32'd0);
      check("init_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Direct strobe at sel=2.
      cycle(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1);
      idle(2);

      // Burst with wrap: 1000, 0001, 0010.
      cycle(1'b1, 2'd3, 1'b1, 2'd2, 1'b0, 1'b1);
      idle(4);

      // Backpressure on the first strobe.
      cycle(1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      idle(3);

      // Back-to-back: second request on the final beat of a burst.
      cycle(1'b1, 2'd0, 1'b1, 2'd2, 1'b0, 1'b1);
      idle(2);
      cycle(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1);
      idle(2);

      // Reset in the middle of a full-length burst.
      cycle(1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 1'b1);
      idle(2);
      reset_mid();
      cycle(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1);
      idle(2);

      // Descending burst (only meaningful with the reverse feature built in).
      cycle(1'b1, 2'd1, 1'b1, 2'd3, 1'b1, 1'b1);
      idle(5);

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0));
         if (i == 200) reset_mid();
      end
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
